// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with run-time pattern load,
// overlap select, registered match pulse and saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b0110,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_z;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;

  logic              w_step;
  logic [PAT_W-1:0]  w_hist_n;
  logic              w_match;
  logic [FILL_W-1:0] w_fill_n;
  logic [CNT_W-1:0]  w_cnt_n;

  assign w_step   = en & ~pat_load;
  assign w_hist_n = {r_hist[PAT_W-2:0], x};
  assign w_match  = w_step
                  && (w_hist_n == r_pat)
                  && (r_fill >= FILL_ARM);

  // Non-overlap restarts the fill so the next match needs all-new bits
  always_comb begin
    w_fill_n = r_fill;
    if (w_match && !overlap)
      w_fill_n = '0;
    else if (r_fill != FILL_MAX)
      w_fill_n = r_fill + 1'b1;
  end

  always_comb begin
    w_cnt_n = r_cnt;
    if (cnt_clr)
      w_cnt_n = '0;
    else if (w_match && (r_cnt != CNT_MAX))
      w_cnt_n = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= PAT_RST;
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_z   <= w_match;
      r_cnt <= w_cnt_n;
      r_sat <= (w_cnt_n == CNT_MAX);
      if (pat_load) begin
        r_pat  <= pat_in;
        r_hist <= '0;
        r_fill <= '0;
      end else if (en) begin
        r_hist <= w_hist_n;
        r_fill <= w_fill_n;
      end
    end
  end

  assign z         = r_z;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: window-queue reference model checked on
// every cycle, plus directed vectors with hand-computed pulses and counts.
module tb_seq_detect_param;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             x;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;

  logic       z_a, sat_a;
  logic [7:0] cnt_a;
  logic       z_b, sat_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b0110), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b0110), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: the window holds the sampled bits that may still
  // form a match; a match is the newest PAT_W bits equalling the pattern.
  bit         win[$];
  logic [3:0] m_pat = 4'b0110;
  bit         m_z = 0;
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;

  function automatic logic [3:0] win_val();
    logic [3:0] v = '0;
    foreach (win[i]) v = {v[2:0], win[i]};
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit hit;
    if (!reset_n) begin
      m_pat = 4'b0110;
      win.delete();
      m_z = 0;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      hit = 0;
      if (pat_load) begin
        m_pat = pat_in;
        win.delete();
      end else if (en) begin
        win.push_back(x);
        if (win.size() > PAT_W) void'(win.pop_front());
        hit = (win.size() == PAT_W) && (win_val() == m_pat);
        if (hit && !overlap) win.delete();
      end
      m_z = hit;
      if (cnt_clr) begin
        m_cnt_a = 0;
        m_cnt_b = 0;
      end else if (hit) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_z_a",   {31'd0, z_a},   {31'd0, m_z});
    chk("model_cnt_a", {24'd0, cnt_a}, m_cnt_a);
    chk("model_sat_a", {31'd0, sat_a}, {31'd0, m_cnt_a == 255});
    chk("model_z_b",   {31'd0, z_b},   {31'd0, m_z});
    chk("model_cnt_b", {30'd0, cnt_b}, m_cnt_b);
    chk("model_sat_b", {31'd0, sat_b}, {31'd0, m_cnt_b == 3});
  end

  task automatic send(input bit b, input bit expz, input bit clr = 0);
    en = 1'b1; x = b; cnt_clr = clr;
    @(posedge clk);
    @(negedge clk);
    chk("vec_z", {31'd0, z_a}, {31'd0, expz});
    en = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0; x = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_z", {31'd0, z_a}, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_z",   {31'd0, z_a},   32'd0);
    chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
    chk("rst_sat", {31'd0, sat_b}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_str(input logic [9:0] bits, input logic [9:0] zs,
                          input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], zs[i]);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; x = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("init_cnt", {24'd0, cnt_a}, 32'd0);

    // overlapping: pulses after bits 4, 7, 10
    overlap = 1'b1;
    send_str(10'b0110110110, 10'b0001001001, 10);
    chk("t1_cnt_a", {24'd0, cnt_a}, 32'd3);
    chk("t1_cnt_b", {30'd0, cnt_b}, 32'd3);
    chk("t1_sat_b", {31'd0, sat_b}, 32'd1);

    // non-overlapping: pulses after bits 4, 10
    do_reset();
    overlap = 1'b0;
    send_str(10'b0110110110, 10'b0001000001, 10);
    chk("t2_cnt_a", {24'd0, cnt_a}, 32'd2);
    chk("t2_sat_b", {31'd0, sat_b}, 32'd0);

    // stall between bits 2 and 3
    do_reset();
    overlap = 1'b1;
    send(0, 0); send(1, 0);
    idle(3);
    send(1, 0); send(0, 1);
    chk("t3_cnt_a", {24'd0, cnt_a}, 32'd1);

    // pattern load after a partial 011
    do_reset();
    send(0, 0); send(1, 0); send(1, 0);
    pat_load = 1'b1; pat_in = 4'b1011; en = 1'b1; x = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_load_z", {31'd0, z_a}, 32'd0);
    pat_load = 1'b0; en = 1'b0;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    chk("t4_cnt_a", {24'd0, cnt_a}, 32'd1);

    // saturation with 1111, then clear coincident with a match
    do_reset();
    overlap = 1'b1;
    pat_load = 1'b1; pat_in = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    pat_load = 1'b0;
    send(1, 0); send(1, 0); send(1, 0);
    for (int i = 0; i < 5; i++) send(1, 1);
    chk("t5_cnt_b", {30'd0, cnt_b}, 32'd3);
    chk("t5_sat_b", {31'd0, sat_b}, 32'd1);
    chk("t5_cnt_a", {24'd0, cnt_a}, 32'd5);
    send(1, 1, 1);
    chk("t5_clr_b", {30'd0, cnt_b}, 32'd0);
    chk("t5_clrsat", {31'd0, sat_b}, 32'd0);
    chk("t5_clr_a", {24'd0, cnt_a}, 32'd0);

    // reset mid-pattern restores 0110 and empties history
    send(0, 0); send(1, 0); send(1, 0);
    do_reset();
    send(0, 0);
    send(0, 0); send(1, 0); send(1, 0); send(0, 1);
    chk("t6_cnt_a", {24'd0, cnt_a}, 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
